// File: rtl/npu_circ_buf_drain_acc_if.sv
// Result handshake from the drain accumulator to the next NPU stage.
// Master drives the sum and valid; slave returns ready.
interface npu_circ_buf_drain_acc_if #(
  parameter int ACC_W = 32
);
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;

  modport master (
    output acc_out,
    output acc_valid,
    input  acc_ready
  );

  modport slave (
    input  acc_out,
    input  acc_valid,
    output acc_ready
  );
endinterface

// File: rtl/npu_circ_buf_drain_acc.sv
// Circular buffer drain: snoops writes to track occupancy, reads a frame,
// sign-extends and saturating-accumulates it, then hands the sum downstream.
module npu_circ_buf_drain_acc #(
  parameter  int DEPTH  = 64,
  parameter  int DATA_W = 16,
  parameter  int ACC_W  = 32,
  parameter  int LEN_W  = 8,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              npu_rst,
  input  logic              npu_circ_buf_write_en,
  output logic              npu_circ_buf_read_en,
  input  logic [DATA_W-1:0] npu_circ_buf_data_output,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  npu_circ_buf_drain_acc_if.master acc_if,
  output logic              busy,
  output logic              sat,
  output logic [OCC_W-1:0]  occupancy
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    HOLD
  } state_e;

  state_e             state_q;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [LEN_W-1:0]   rem_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_out_q;
  logic               acc_valid_q;
  logic               sat_q;
  logic               rd_d_q;
  logic               rd_en;
  logic               ovf;
  logic [ACC_W:0]     dext;
  logic [ACC_W:0]     sum;

  assign rd_en = (state_q == READ) && (occ_q != '0) && (rem_q != '0);

  assign npu_circ_buf_read_en = rd_en;
  assign acc_if.acc_out       = acc_out_q;
  assign acc_if.acc_valid     = acc_valid_q;
  assign busy                 = (state_q != IDLE);
  assign sat                  = sat_q;
  assign occupancy            = occ_q;

  always_comb begin
    occ_d = occ_q;
    unique case ({npu_circ_buf_write_en, rd_en})
      2'b10: if (occ_q != OCC_W'(DEPTH)) occ_d = occ_q + 1'b1;
      2'b01: if (occ_q != '0) occ_d = occ_q - 1'b1;
      default: ;
    endcase
  end

  // One guard bit above the accumulator exposes signed overflow.
  assign dext = {{(ACC_W + 1 - DATA_W){npu_circ_buf_data_output[DATA_W-1]}},
                 npu_circ_buf_data_output};
  assign sum  = {acc_q[ACC_W-1], acc_q} + dext;

  always_comb begin
    ovf   = sum[ACC_W] ^ sum[ACC_W-1];
    acc_d = sum[ACC_W-1:0];
    if (ovf) begin
      acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                         : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge CLK or posedge npu_rst) begin
    if (npu_rst) begin
      state_q     <= IDLE;
      occ_q       <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      rd_d_q      <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      rd_d_q <= rd_en;
      if (rd_d_q) begin
        acc_q <= acc_d;
        if (ovf) sat_q <= 1'b1;
      end
      if (rd_en) rem_q <= rem_q - 1'b1;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_q <= '0;
            sat_q <= 1'b0;
            if (frame_len != '0) begin
              rem_q   <= frame_len;
              state_q <= READ;
            end else begin
              acc_out_q   <= '0;
              acc_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end
        end
        READ: begin
          if (rd_en && rem_q == LEN_W'(1)) state_q <= DRAIN;
        end
        DRAIN: begin
          acc_out_q   <= acc_d;
          acc_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (acc_if.acc_ready) begin
            acc_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_circ_buf_drain_acc.sv
// Directed bench for the circular buffer drain accumulator,
// with a 32-bit and a 17-bit accumulator build fed the same stimulus.
module tb_npu_circ_buf_drain_acc;

  logic        CLK = 1'b0;
  logic        rst;
  logic        wr;
  logic [15:0] wdata;
  logic        start;
  logic [7:0]  frame_len;
  logic [15:0] rdata;
  logic        read_en, read_en17;
  logic        busy, busy17;
  logic        sat, sat17;
  logic [6:0]  occ, occ17;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int vld_cnt = 0;
  int viol = 0;
  logic [15:0] bufq[$];

  npu_circ_buf_drain_acc_if #(.ACC_W(32)) bus ();
  npu_circ_buf_drain_acc_if #(.ACC_W(17)) b17 ();

  npu_circ_buf_drain_acc u_dut (
    .CLK                     (CLK),
    .npu_rst                 (rst),
    .npu_circ_buf_write_en   (wr),
    .npu_circ_buf_read_en    (read_en),
    .npu_circ_buf_data_output(rdata),
    .start                   (start),
    .frame_len               (frame_len),
    .acc_if                  (bus),
    .busy                    (busy),
    .sat                     (sat),
    .occupancy               (occ)
  );

  npu_circ_buf_drain_acc #(.ACC_W(17)) u_d17 (
    .CLK                     (CLK),
    .npu_rst                 (rst),
    .npu_circ_buf_write_en   (wr),
    .npu_circ_buf_read_en    (read_en17),
    .npu_circ_buf_data_output(rdata),
    .start                   (start),
    .frame_len               (frame_len),
    .acc_if                  (b17),
    .busy                    (busy17),
    .sat                     (sat17),
    .occupancy               (occ17)
  );

  always #5 CLK = ~CLK;

  // Buffer model: read data appears the cycle after read_en.
  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      bufq.delete();
      rdata <= '0;
    end else begin
      if (wr) bufq.push_back(wdata);
      if (read_en && bufq.size() > 0) rdata <= bufq.pop_front();
    end
  end

  always @(posedge CLK) begin
    if (read_en) rd_cnt <= rd_cnt + 1;
    if (bus.acc_valid) vld_cnt <= vld_cnt + 1;
    if (read_en && occ == 7'd0) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    wr = 1'b1;
    wdata = w;
    tick();
    wr = 1'b0;
  endtask

  task automatic go(input logic [7:0] len);
    start = 1'b1;
    frame_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.acc_valid && n < 200) begin
      tick();
      n++;
    end
    if (!bus.acc_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int n, rb, vb, xb;

  initial begin
    rst = 1'b1;
    wr = 1'b0;
    wdata = '0;
    start = 1'b0;
    frame_len = '0;
    bus.acc_ready = 1'b1;
    b17.acc_ready = 1'b1;
    tick();
    tick();
    chk("rst_rd", read_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_occ", occ, 0);
    chk("rst_out", bus.acc_out, 0);
    chk("rst_vld", bus.acc_valid, 0);
    chk("rst_sat", sat, 0);
    rst = 1'b0;
    tick();

    // Frame of 7 with data already present
    for (int i = 1; i <= 7; i++) push(16'(i));
    chk("t1_occ7", occ, 7);
    rb = rd_cnt;
    vb = vld_cnt;
    go(8'd7);
    frame_len = 8'd2;
    chk("t1_lat_rd", read_en, 1);
    wait_valid(n);
    chk("t1_lat_vld", n, 8);
    chk("t1_sum", bus.acc_out, 28);
    chk("t1_reads", rd_cnt - rb, 7);
    chk("t1_occ0", occ, 0);
    chk("t1_sat", sat, 0);
    tick();
    tick();
    chk("t1_vld_once", vld_cnt - vb, 1);
    chk("t1_idle", busy, 0);

    // Frame starts empty, words trickle in
    rb = rd_cnt;
    xb = viol;
    go(8'd4);
    chk("t2_stall", read_en, 0);
    chk("t2_busy", busy, 1);
    push(16'h0010); tick(); tick();
    push(16'hFFFF); tick(); tick();
    push(16'h0005); tick(); tick();
    push(16'h8000); tick(); tick();
    wait_valid(n);
    chk("t2_sum", bus.acc_out, 32'hFFFF_8014);
    chk("t2_sum17", b17.acc_out, 17'h1_8014);
    chk("t2_reads", rd_cnt - rb, 4);
    chk("t2_no_empty_rd", viol - xb, 0);
    chk("t2_sat", sat, 0);
    tick();

    // Simultaneous write and read leaves occupancy unchanged
    push(16'd100);
    push(16'd200);
    push(16'd300);
    chk("t3_occ3", occ, 3);
    go(8'd4);
    chk("t3_rd", read_en, 1);
    wr = 1'b1;
    wdata = 16'd5;
    tick();
    wr = 1'b0;
    chk("t3_both", occ, 3);
    wait_valid(n);
    chk("t3_sum", bus.acc_out, 605);
    chk("t3_occ0", occ, 0);
    tick();
    for (int i = 0; i < 70; i++) push(16'(i));
    chk("t3_occ_cap", occ, 64);
    do_reset();
    chk("t3_occ_rst", occ, 0);

    // Saturation on the 17-bit build, sat cleared by next start
    for (int i = 0; i < 4; i++) push(16'h7FFF);
    go(8'd4);
    wait_valid(n);
    chk("t4_clamp17", b17.acc_out, 17'h0_FFFF);
    chk("t4_sat17", sat17, 1);
    chk("t4_sum32", bus.acc_out, 32'h0001_FFFC);
    chk("t4_sat32", sat, 0);
    tick();
    chk("t4_sat_sticky", sat17, 1);
    go(8'd0);
    chk("t4_len0_vld", b17.acc_valid, 1);
    chk("t4_len0_out", b17.acc_out, 0);
    chk("t4_sat_clr", sat17, 0);
    tick();
    chk("t4_len0_done", bus.acc_valid, 0);

    // Back-pressure: hold stable, ignore start
    bus.acc_ready = 1'b0;
    b17.acc_ready = 1'b0;
    push(16'd3);
    push(16'd4);
    go(8'd2);
    wait_valid(n);
    rb = rd_cnt;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        start = 1'b1;
        frame_len = 8'd5;
        wr = 1'b1;
        wdata = 16'd9;
      end
      tick();
      start = 1'b0;
      wr = 1'b0;
      chk("t5_out", bus.acc_out, 7);
      chk("t5_vld", bus.acc_valid, 1);
      chk("t5_busy", busy, 1);
    end
    chk("t5_no_rd", rd_cnt - rb, 0);
    bus.acc_ready = 1'b1;
    b17.acc_ready = 1'b1;
    tick();
    chk("t5_idle", busy, 0);
    chk("t5_vld_clr", bus.acc_valid, 0);
    tick();
    chk("t5_still_idle", busy, 0);

    // Reset mid-frame, then a clean frame
    do_reset();
    for (int i = 1; i <= 10; i++) push(16'(i));
    go(8'd10);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_rd", read_en, 0);
    chk("t6_busy", busy, 0);
    chk("t6_occ", occ, 0);
    chk("t6_out", bus.acc_out, 0);
    chk("t6_vld", bus.acc_valid, 0);
    chk("t6_sat", sat, 0);
    tick();
    rst = 1'b0;
    tick();
    push(16'd10);
    push(16'd20);
    push(16'd30);
    go(8'd3);
    wait_valid(n);
    chk("t6_sum", bus.acc_out, 60);
    chk("t6_occ0", occ, 0);
    tick();
    chk("t6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
